// File: rtl/vga_timing_pipe.sv
// rtl/vga_timing_pipe.sv - parametrised VGA timing generator with lead pixel requests and aligned sync output stage
module vga_timing_pipe #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CBITS    = 2,
  parameter int PIPE_LAT = 2,
  parameter int SCALE_SH = 3,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int CW      = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [3*CBITS-1:0] rgb_in,
  output logic [CW-1:0]    req_x,
  output logic [CW-1:0]    req_y,
  output logic [CW-1:0]    req_xc,
  output logic [CW-1:0]    req_yc,
  output logic             req_active,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic [3*CBITS-1:0] rgb_out,
  output logic             frame_start,
  output logic             line_start
);

  generate
    if (PIPE_LAT < 1 || PIPE_LAT > 8) begin : g_bad_lat
      $error("vga_timing_pipe: PIPE_LAT must be in 1..8");
    end
  endgenerate

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HA     = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VA     = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  // Delay-line bit layout: {line_start, frame_start, de, vs, hs}; syncs carried at pad polarity
  localparam logic [4:0] SR_RST = {3'b000, ~VS_POL, ~HS_POL};

  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          hs_lvl;
  logic          vs_lvl;
  logic          frame_mark;
  logic          line_mark;
  logic [4:0]    raw;
  logic [4:0]    sr [PIPE_LAT];
  logic          act_pre;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (enable) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CW'(1);
      end else begin
        hcnt <= hcnt + CW'(1);
      end
    end
  end

  assign req_x      = hcnt;
  assign req_y      = vcnt;
  assign req_xc     = hcnt >> SCALE_SH;
  assign req_yc     = vcnt >> SCALE_SH;
  assign req_active = (hcnt < HA) && (vcnt < VA);

  assign hs_lvl     = (hcnt >= HS_BEG && hcnt < HS_END) ? HS_POL : ~HS_POL;
  assign vs_lvl     = (vcnt >= VS_BEG && vcnt < VS_END) ? VS_POL : ~VS_POL;
  assign frame_mark = (hcnt == '0) && (vcnt == '0);
  assign line_mark  = (hcnt == '0) && (vcnt < VA);
  assign raw        = {line_mark, frame_mark, req_active, vs_lvl, hs_lvl};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) sr[i] <= SR_RST;
    end else if (enable) begin
      sr[0] <= raw;
      for (int i = 1; i < PIPE_LAT; i++) sr[i] <= sr[i-1];
    end
  end

  // Colour is the last pipeline stage, so it gates on the active flag one stage short of de
  generate
    if (PIPE_LAT == 1) begin : g_act_comb
      assign act_pre = req_active;
    end else begin : g_act_reg
      assign act_pre = sr[PIPE_LAT-2][2];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out <= '0;
    end else if (enable) begin
      rgb_out <= act_pre ? rgb_in : '0;
    end
  end

  assign hs          = sr[PIPE_LAT-1][0];
  assign vs          = sr[PIPE_LAT-1][1];
  assign de          = sr[PIPE_LAT-1][2];
  assign frame_start = sr[PIPE_LAT-1][3];
  assign line_start  = sr[PIPE_LAT-1][4];

endmodule

// File: tb/tb_vga_timing_pipe.sv
// tb/tb_vga_timing_pipe.sv - directed self-checking bench for vga_timing_pipe on a reduced 25x11 raster
module tb_vga_timing_pipe;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 4;
  localparam int VA = 6, VFP = 1, VSY = 2, VBP = 2;
  localparam int HT = 25, VT = 11, FRAME = 275;
  localparam int LAT = 3;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [5:0]    rgb_in;
  logic [CW-1:0] req_x, req_y, req_xc, req_yc;
  logic          req_active, hs, vs, de, frame_start, line_start;
  logic [5:0]    rgb_out;
  logic [5:0]    s1, s2;

  int checks = 0;
  int errors = 0;
  int n = 0;

  always #5 clk = ~clk;

  vga_timing_pipe #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b1), .CBITS(2), .PIPE_LAT(LAT), .SCALE_SH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rgb_in(rgb_in),
    .req_x(req_x), .req_y(req_y), .req_xc(req_xc), .req_yc(req_yc),
    .req_active(req_active), .hs(hs), .vs(vs), .de(de), .rgb_out(rgb_out),
    .frame_start(frame_start), .line_start(line_start)
  );

  // Pixel source with LAT-1 register stages: colour = {y[0], x} of the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else if (enable) begin
      s1 <= {req_y[0], req_x};
      s2 <= s1;
    end
  end
  assign rgb_in = s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int p, x, y, lx, ly;
    logic e_hs, e_vs, e_de, e_fs, e_ls;
    logic [5:0] e_rgb;
    lx = n % HT;
    ly = (n / HT) % VT;
    if (n < LAT) begin
      e_hs = 1'b1; e_vs = 1'b0; e_de = 1'b0; e_fs = 1'b0; e_ls = 1'b0; e_rgb = '0;
    end else begin
      p = (n - LAT) % FRAME;
      x = p % HT;
      y = p / HT;
      e_hs  = !(x >= HA + HFP && x < HA + HFP + HSY);
      e_vs  = (y >= VA + VFP && y < VA + VFP + VSY);
      e_de  = (x < HA) && (y < VA);
      e_fs  = (x == 0) && (y == 0);
      e_ls  = (x == 0) && (y < VA);
      e_rgb = e_de ? 6'((y % 2) * 32 + x) : 6'd0;
    end
    chk("hs", 32'(hs), 32'(e_hs));
    chk("vs", 32'(vs), 32'(e_vs));
    chk("de", 32'(de), 32'(e_de));
    chk("rgb_out", 32'(rgb_out), 32'(e_rgb));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("line_start", 32'(line_start), 32'(e_ls));
    chk("req_x", 32'(req_x), 32'(lx));
    chk("req_y", 32'(req_y), 32'(ly));
    chk("req_xc", 32'(req_xc), 32'(lx >> 2));
    chk("req_yc", 32'(req_yc), 32'(ly >> 2));
    chk("req_active", 32'(req_active), 32'((lx < HA) && (ly < VA)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (enable && rst_n) n++;
    check_all();
  endtask

  task automatic run_until_p(input int target);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (n >= LAT && ((n - LAT) % FRAME) == target) found = 1'b1;
    end
    chk("reach_target", 32'(found), 32'd1);
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    n = 0;
    chk("midrst_hs", 32'(hs), 32'd1);
    chk("midrst_vs", 32'(vs), 32'd0);
    chk("midrst_de", 32'(de), 32'd0);
    chk("midrst_rgb", 32'(rgb_out), 32'd0);
    check_all();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hs", 32'(hs), 32'd1);
    chk("reset_vs", 32'(vs), 32'd0);
    chk("reset_de", 32'(de), 32'd0);
    chk("reset_rgb", 32'(rgb_out), 32'd0);
    check_all();

    rst_n  = 1'b1;
    enable = 1'b1;
    step();
    chk("first_de_e1", 32'(de), 32'd0);
    step();
    chk("first_de_e2", 32'(de), 32'd0);
    step();
    chk("first_de_e3", 32'(de), 32'd1);
    chk("first_frame_start", 32'(frame_start), 32'd1);

    // One full frame plus a few lines under the raster model
    for (int i = 0; i < FRAME + 40; i++) step();

    run_until_p(0);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (frame_start !== 1'b1 && cnt < 2 * FRAME);
    chk("frame_period", 32'(cnt), 32'(FRAME));

    // Freeze mid-line at output x=5, y=1
    run_until_p(HT + 5);
    chk("freeze_rgb_before", 32'(rgb_out), 32'd37);
    enable = 1'b0;
    for (int i = 0; i < 37; i++) step();
    chk("freeze_rgb_held", 32'(rgb_out), 32'd37);
    enable = 1'b1;
    step();
    chk("resume_rgb_x6", 32'(rgb_out), 32'd38);
    for (int i = 0; i < 30; i++) step();

    // Reset during active video, then during hs and vs pulses
    run_until_p(2 * HT + 9);
    chk("pre_reset_de", 32'(de), 32'd1);
    mid_reset();
    for (int i = 0; i < 60; i++) step();

    run_until_p(7 * HT + 19);
    chk("pre_reset_hs", 32'(hs), 32'd0);
    chk("pre_reset_vs", 32'(vs), 32'd1);
    mid_reset();
    for (int i = 0; i < 40; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
